// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO and serialises each word as a UART frame on tx.
// Define PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic tx_d, bit_end;
`ifdef PARITY_EN
  logic par, par_n;
`endif
  assign bit_end = baud == BAUD_LAST;
  assign fifo_rd = state == IDLE && !fifo_empty && !rst;
  assign busy = state != IDLE;
  assign done = state == STOP && bit_end && bit_cnt == STOP_LAST;
  always_comb begin
    state_n = state;
    baud_n = bit_end ? '0 : baud + BW'(1);
    bit_n = bit_cnt;
    shift_n = shift;
`ifdef PARITY_EN
    par_n = par;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n = '0;
        if (!fifo_empty) state_n = LOAD;
      end
      LOAD: begin
        shift_n = fifo_data;
`ifdef PARITY_EN
        par_n = ^fifo_data;
`endif
        baud_n = '0;
        state_n = START;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_n = bit_cnt + CW'(1);
        if (bit_cnt == DATA_LAST) begin
          bit_n = '0;
`ifdef PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        bit_n = bit_cnt + CW'(1);
        if (bit_cnt == STOP_LAST) begin
          bit_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is registered, so it is driven from the state being entered
`ifdef PARITY_EN
    tx_d = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
    tx_d = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
`ifdef PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      tx <= tx_d;
`ifdef PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx (STOP_BITS 1 and 2) fed by small FIFO models.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [7:0] fd1 = '0;
  logic [7:0] fd2 = '0;
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
  logic e1, e2, rd1, rd2, tx1, tx2, b1, b2, d1, d2;
  int checks = 0, errors = 0;
  assign e1 = wp1 == rp1;
  assign e2 = wp2 == rp2;
  always @(posedge clk) if (rd1) begin
    fd1 <= mem1[rp1[3:0]];
    rp1 <= rp1 + 1;
  end
  always @(posedge clk) if (rd2) begin
    fd2 <= mem2[rp2[3:0]];
    rp2 <= rp2 + 1;
  end
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .fifo_empty(e1), .fifo_data(fd1),
    .fifo_rd(rd1), .tx(tx1), .busy(b1), .done(d1));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .fifo_empty(e2), .fifo_data(fd2),
    .fifo_rd(rd2), .tx(tx2), .busy(b2), .done(d2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input bit sel, input logic [7:0] w);
    if (sel) begin
      mem2[wp2[3:0]] = w;
      wp2++;
    end else begin
      mem1[wp1[3:0]] = w;
      wp1++;
    end
  endtask
  task automatic wait_rd(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? rd2 : rd1) && n < 200);
    check("rd_pulse", sel ? rd2 : rd1, 1);
  endtask
  // Expects to be called so the next negedge (or a later one) is the IDLE cycle issuing the read.
  task automatic run_frame(input bit sel, input logic [7:0] w, input int stops, output int n);
    logic [15:0] fb;
    int nb;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = w[i];
    nb = 9;
`ifdef PARITY_EN
    fb[nb] = ^w;
    nb++;
`endif
    for (int s = 0; s < stops; s++) begin
      fb[nb] = 1'b1;
      nb++;
    end
    wait_rd(sel, n);
    @(negedge clk);
    check("load_tx", sel ? tx2 : tx1, 1);
    check("load_busy", sel ? b2 : b1, 1);
    check("load_rd", sel ? rd2 : rd1, 0);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("tx_b%0d_c%0d", b, c), sel ? tx2 : tx1, fb[b]);
        check($sformatf("done_b%0d_c%0d", b, c), sel ? d2 : d1, (b == nb - 1 && c == 3) ? 1 : 0);
        check($sformatf("rd_b%0d_c%0d", b, c), sel ? rd2 : rd1, 0);
        check($sformatf("busy_b%0d_c%0d", b, c), sel ? b2 : b1, 1);
      end
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx1, 1);
    check("rst_busy", b1, 0);
    check("rst_done", d1, 0);
    check("rst_rd", rd1, 0);
    @(posedge clk); #1;
    push(0, 8'hA5);
    @(negedge clk);
    check("rst_rd_nonempty", rd1, 0);
    check("rst_busy_nonempty", b1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0, 8'hA5, 1, n);
    check("a5_rd_latency", n, 1);
    @(negedge clk);
    check("a5_idle_busy", b1, 0);
    check("a5_idle_tx", tx1, 1);
    check("a5_fifo_empty", e1, 1);
    @(posedge clk); #1;
    push(0, 8'h07);
    run_frame(0, 8'h07, 1, n);
    @(posedge clk); #1;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    run_frame(0, 8'h11, 1, n);
    run_frame(0, 8'h22, 1, n);
    check("gap_1_2", n, 1);
    run_frame(0, 8'h33, 1, n);
    check("gap_2_3", n, 1);
    @(negedge clk);
    check("b2b_busy_low", b1, 0);
    check("b2b_rd_low", rd1, 0);
    check("b2b_fifo_empty", e1, 1);
    check("b2b_reads", rp1, 5);
    @(posedge clk); #1;
    push(0, 8'hFF);
    push(0, 8'h3C);
    wait_rd(0, n);
    repeat (1 + 4 + 12 + 2) @(negedge clk);
    check("mid_busy_pre", b1, 1);
    rst = 1'b1;
    #1;
    check("abort_tx", tx1, 1);
    check("abort_busy", b1, 0);
    check("abort_rd", rd1, 0);
    check("abort_done", d1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0, 8'h3C, 1, n);
    check("abort_next_latency", n, 1);
    @(negedge clk);
    check("abort_fifo_empty", e1, 1);
    check("abort_busy_end", b1, 0);
    @(posedge clk); #1;
    push(1, 8'h00);
    run_frame(1, 8'h00, 2, n);
    @(negedge clk);
    check("stop2_busy_end", b2, 0);
    check("stop2_done_end", d2, 0);
    check("dut1_quiet", b1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
